// File: rtl/comm_pkg.sv
// Shared constants, state encoding and byte-count helpers for the frame decoder.
package comm_pkg;

  // Message types
  localparam logic [7:0] MsgSysReset = 8'h01;
  localparam logic [7:0] MsgCfgWrite = 8'h02;
  localparam logic [7:0] MsgBaseAddr = 8'h04;
  localparam logic [7:0] MsgRamData  = 8'h05;

  // Response codes
  localparam logic [7:0] RespAck     = 8'h06;
  localparam logic [7:0] RespNakChk  = 8'h15;
  localparam logic [7:0] RespNakLen  = 8'h16;
  localparam logic [7:0] RespNakType = 8'h17;
  localparam logic [7:0] RespNakArg  = 8'h18;

  typedef enum logic [2:0] {
    StIdle,
    StType,
    StPayload,
    StCheck,
    StResp
  } state_e;

  function automatic int unsigned data_bytes(input int unsigned width);
    return width / 8;
  endfunction

  function automatic int unsigned cfg_bytes(input int unsigned width);
    return width / 8;
  endfunction

  function automatic int unsigned addr_bytes(input int unsigned width);
    return (width + 7) / 8;
  endfunction

endpackage

// File: rtl/comm_frame_timeout.sv
// Inter-byte idle timer: reloads on every received byte, pulses expire once the
// programmed number of idle clocks has elapsed while enabled.
module comm_frame_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic restart,
  output logic expire
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LOAD = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;

  // Down-counter, reloaded on each byte, parked at zero until the next reload
  always_ff @(posedge clk) begin
    if (reset || restart) begin
      cnt_q <= LOAD;
    end else if (enable && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign expire = enable && !restart && (cnt_q == '0);

endmodule

// File: rtl/comm_frame_decoder.sv
// Length-prefixed, checksummed command frame decoder: streams RAM writes,
// stages and atomically commits config/base-address updates, answers ACK/NAK.
module comm_frame_decoder
  import comm_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned CFG_WIDTH = 16,
  parameter int unsigned NUM_CFG = 4,
  parameter logic [NUM_CFG*CFG_WIDTH-1:0] CFG_INIT = '0,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          rx_valid,
  input  logic [7:0]                    rx_data,
  output logic                          tx_valid,
  input  logic                          tx_ready,
  output logic [7:0]                    tx_data,
  output logic                          wr_enable,
  output logic [ADDR_WIDTH-1:0]         wr_addr,
  output logic [DATA_WIDTH-1:0]         wr_data,
  output logic [NUM_CFG*CFG_WIDTH-1:0]  cfg,
  output logic                          cfg_update,
  output logic                          sys_reset
);

  localparam int unsigned DATA_BYTES = data_bytes(DATA_WIDTH);
  localparam int unsigned CFG_BYTES  = cfg_bytes(CFG_WIDTH);
  localparam int unsigned ADDR_BYTES = addr_bytes(ADDR_WIDTH);
  localparam logic [7:0] LenSys     = 8'd2;
  localparam logic [7:0] LenCfg     = 8'(2 + CFG_BYTES);
  localparam logic [7:0] LenBase    = 8'(1 + ADDR_BYTES);
  localparam logic [7:0] DataBytesB = 8'(DATA_BYTES);
  localparam logic [7:0] WordLast   = 8'(DATA_BYTES - 1);

  state_e                         state_q, state_d;
  logic [7:0]                     len_q, len_d, remain_q, remain_d, type_q, type_d;
  logic [7:0]                     sum_q, sum_d, word_cnt_q, word_cnt_d, cfg_idx_q, cfg_idx_d;
  logic                           err_type_q, err_type_d, err_len_q, err_len_d;
  logic                           first_q, first_d, rst_req_q, rst_req_d;
  logic [DATA_WIDTH-1:0]          word_q, word_d, wr_data_q, wr_data_d;
  logic [ADDR_WIDTH-1:0]          word_idx_q, word_idx_d, wr_addr_q, wr_addr_d;
  logic [ADDR_WIDTH-1:0]          addr_sh_q, addr_sh_d, base_addr_q, base_addr_d;
  logic [CFG_WIDTH-1:0]           cfg_sh_q, cfg_sh_d;
  logic [NUM_CFG*CFG_WIDTH-1:0]   cfg_q, cfg_d;
  logic                           tx_valid_q, tx_valid_d, wr_enable_q, wr_enable_d;
  logic                           cfg_update_q, cfg_update_d, sys_reset_q, sys_reset_d;
  logic [7:0]                     tx_data_q, tx_data_d;

  logic       expire, timer_en;
  logic       type_known, type_len_ok, arg_err;
  logic [7:0] len_m1, sum_next, resp_code;

  assign timer_en = (state_q == StType) || (state_q == StPayload) || (state_q == StCheck);

  comm_frame_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .enable (timer_en),
    .restart(rx_valid),
    .expire (expire)
  );

  // Classify the incoming TYPE byte and check LEN against it
  always_comb begin
    len_m1      = len_q - 8'd1;
    type_known  = 1'b1;
    type_len_ok = 1'b0;
    case (rx_data)
      MsgSysReset: type_len_ok = (len_q == LenSys);
      MsgCfgWrite: type_len_ok = (len_q == LenCfg);
      MsgBaseAddr: type_len_ok = (len_q == LenBase);
      MsgRamData:  type_len_ok = (len_m1 != 8'd0) && ((len_m1 % DataBytesB) == 8'd0);
      default:     type_known  = 1'b0;
    endcase
  end

  // Response selection at CHK: checksum beats type beats length beats argument
  always_comb begin
    sum_next = sum_q + rx_data;
    arg_err  = (type_q == MsgCfgWrite) && (32'(cfg_idx_q) >= NUM_CFG);
    if (sum_next != 8'd0)   resp_code = RespNakChk;
    else if (err_type_q)    resp_code = RespNakType;
    else if (err_len_q)     resp_code = RespNakLen;
    else if (arg_err)       resp_code = RespNakArg;
    else                    resp_code = RespAck;
  end

  // Frame FSM next-state, payload assembly and commit logic
  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    remain_d     = remain_q;
    type_d       = type_q;
    sum_d        = sum_q;
    word_cnt_d   = word_cnt_q;
    cfg_idx_d    = cfg_idx_q;
    err_type_d   = err_type_q;
    err_len_d    = err_len_q;
    first_d      = first_q;
    rst_req_d    = rst_req_q;
    word_d       = word_q;
    word_idx_d   = word_idx_q;
    addr_sh_d    = addr_sh_q;
    cfg_sh_d     = cfg_sh_q;
    base_addr_d  = base_addr_q;
    cfg_d        = cfg_q;
    tx_valid_d   = tx_valid_q;
    tx_data_d    = tx_data_q;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    wr_enable_d  = 1'b0;
    cfg_update_d = 1'b0;
    sys_reset_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        // LEN=0 is dropped without leaving idle
        if (rx_valid && (rx_data != 8'd0)) begin
          len_d      = rx_data;
          remain_d   = rx_data - 8'd1;
          sum_d      = rx_data;
          first_d    = 1'b1;
          rst_req_d  = 1'b0;
          cfg_idx_d  = '0;
          cfg_sh_d   = '0;
          addr_sh_d  = '0;
          word_d     = '0;
          word_cnt_d = '0;
          word_idx_d = '0;
          state_d    = StType;
        end
      end
      StType: begin
        if (expire) begin
          state_d = StIdle;
        end else if (rx_valid) begin
          type_d     = rx_data;
          sum_d      = sum_next;
          err_type_d = !type_known;
          err_len_d  = type_known && !type_len_ok;
          state_d    = (remain_q == 8'd0) ? StCheck : StPayload;
        end
      end
      StPayload: begin
        if (expire) begin
          state_d = StIdle;
        end else if (rx_valid) begin
          sum_d    = sum_next;
          remain_d = remain_q - 8'd1;
          first_d  = 1'b0;
          if (remain_q == 8'd1) state_d = StCheck;
          case (type_q)
            MsgSysReset: if (first_q) rst_req_d = rx_data[0];
            MsgCfgWrite: begin
              if (first_q) cfg_idx_d = rx_data;
              else         cfg_sh_d  = (cfg_sh_q << 8) | CFG_WIDTH'(rx_data);
            end
            // Shifting through an ADDR_WIDTH register truncates the MSB-first value
            MsgBaseAddr: addr_sh_d = (addr_sh_q << 8) | ADDR_WIDTH'(rx_data);
            MsgRamData: begin
              if (!err_len_q) begin
                word_d = (word_q << 8) | DATA_WIDTH'(rx_data);
                if (word_cnt_q == WordLast) begin
                  word_cnt_d  = '0;
                  wr_enable_d = 1'b1;
                  wr_addr_d   = base_addr_q + word_idx_q;
                  wr_data_d   = (word_q << 8) | DATA_WIDTH'(rx_data);
                  word_idx_d  = word_idx_q + ADDR_WIDTH'(1);
                end else begin
                  word_cnt_d = word_cnt_q + 8'd1;
                end
              end
            end
            default: ;
          endcase
        end
      end
      StCheck: begin
        if (expire) begin
          state_d = StIdle;
        end else if (rx_valid) begin
          tx_valid_d = 1'b1;
          tx_data_d  = resp_code;
          state_d    = StResp;
          if (resp_code == RespAck) begin
            if (type_q == MsgCfgWrite) begin
              for (int i = 0; i < NUM_CFG; i++) begin
                if (cfg_idx_q == 8'(i)) cfg_d[i*CFG_WIDTH +: CFG_WIDTH] = cfg_sh_q;
              end
              cfg_update_d = 1'b1;
            end
            if (type_q == MsgBaseAddr) base_addr_d = addr_sh_q;
            if (type_q == MsgSysReset) sys_reset_d = rst_req_q;
          end
        end
      end
      StResp: begin
        // Incoming bytes are ignored until the response is taken
        if (tx_ready) begin
          tx_valid_d = 1'b0;
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      len_q        <= '0;
      remain_q     <= '0;
      type_q       <= '0;
      sum_q        <= '0;
      word_cnt_q   <= '0;
      cfg_idx_q    <= '0;
      err_type_q   <= 1'b0;
      err_len_q    <= 1'b0;
      first_q      <= 1'b0;
      rst_req_q    <= 1'b0;
      word_q       <= '0;
      word_idx_q   <= '0;
      addr_sh_q    <= '0;
      cfg_sh_q     <= '0;
      base_addr_q  <= '0;
      cfg_q        <= CFG_INIT;
      tx_valid_q   <= 1'b0;
      tx_data_q    <= '0;
      wr_enable_q  <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      cfg_update_q <= 1'b0;
      sys_reset_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      remain_q     <= remain_d;
      type_q       <= type_d;
      sum_q        <= sum_d;
      word_cnt_q   <= word_cnt_d;
      cfg_idx_q    <= cfg_idx_d;
      err_type_q   <= err_type_d;
      err_len_q    <= err_len_d;
      first_q      <= first_d;
      rst_req_q    <= rst_req_d;
      word_q       <= word_d;
      word_idx_q   <= word_idx_d;
      addr_sh_q    <= addr_sh_d;
      cfg_sh_q     <= cfg_sh_d;
      base_addr_q  <= base_addr_d;
      cfg_q        <= cfg_d;
      tx_valid_q   <= tx_valid_d;
      tx_data_q    <= tx_data_d;
      wr_enable_q  <= wr_enable_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      cfg_update_q <= cfg_update_d;
      sys_reset_q  <= sys_reset_d;
    end
  end

  assign tx_valid   = tx_valid_q;
  assign tx_data    = tx_data_q;
  assign wr_enable  = wr_enable_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign cfg        = cfg_q;
  assign cfg_update = cfg_update_q;
  assign sys_reset  = sys_reset_q;

endmodule

// File: tb/tb_comm_frame_decoder.sv
// Bench for comm_frame_decoder: table of frames with expected responses, a
// scoreboard for response bytes and RAM writes, and hand-written corner cases.
module tb_comm_frame_decoder;

  localparam int unsigned TO = 64;
  localparam logic [63:0] INIT = 64'h4444_3333_2222_1111;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        tx_ready = 1'b1;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        wr_enable;
  logic [11:0] wr_addr;
  logic [15:0] wr_data;
  logic [63:0] cfg;
  logic        cfg_update;
  logic        sys_reset;

  comm_frame_decoder #(
    .DATA_WIDTH    (16),
    .ADDR_WIDTH    (12),
    .CFG_WIDTH     (16),
    .NUM_CFG       (4),
    .CFG_INIT      (INIT),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .tx_data   (tx_data),
    .wr_enable (wr_enable),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .cfg       (cfg),
    .cfg_update(cfg_update),
    .sys_reset (sys_reset)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  int upd_cnt = 0;
  int srst_cnt = 0;
  logic [7:0]  exp_tx[$];
  logic [27:0] exp_wr[$];
  logic [63:0] cfg_m = INIT;
  logic [11:0] base_m = 12'h000;

  typedef struct {
    string      name;
    logic [63:0] body;    // right-aligned LEN..last payload byte
    int         n;
    logic [7:0] corrupt;  // added to the correct CHK
    logic [7:0] resp;
    bit         upd;
    bit         srst;
  } vec_t;
  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic flag(input string name);
    checks++;
    $display("FAIL %s", name);
  endtask

  // Scoreboard side: pop expected items as the DUT produces them
  always @(negedge clk) begin
    if (cfg_update) upd_cnt++;
    if (sys_reset) srst_cnt++;
    if (tx_valid && tx_ready) begin
      if (exp_tx.size() == 0) flag($sformatf("tx_unexpected: got %h expected none", tx_data));
      else check("tx_data", 64'(tx_data), 64'(exp_tx.pop_front()));
    end
    if (wr_enable) begin
      if (exp_wr.size() == 0) flag($sformatf("wr_unexpected: got %h/%h", wr_addr, wr_data));
      else check("wr_addr_data", 64'({wr_addr, wr_data}), 64'(exp_wr.pop_front()));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
  endtask

  function automatic logic [7:0] byte_at(input logic [63:0] body, input int n, input int i);
    return 8'(body >> (8 * (n - 1 - i)));
  endfunction

  task automatic send_body(input logic [63:0] body, input int n, input logic [7:0] corrupt);
    logic [7:0] sum;
    logic [7:0] b;
    sum = 8'h00;
    for (int i = 0; i < n; i++) begin
      b = byte_at(body, n, i);
      send_byte(b);
      sum = sum + b;
      repeat ($urandom_range(0, 2)) tick();
    end
    send_byte((8'h00 - sum) + corrupt);
  endtask

  task automatic wait_resp(input string name);
    for (int c = 0; c < 60 && exp_tx.size() != 0; c++) tick();
    check({name, "_resp_done"}, 64'(exp_tx.size()), 64'd0);
    exp_tx.delete();
  endtask

  task automatic model_commit(input logic [63:0] body, input int n);
    logic [7:0] t;
    logic [15:0] v;
    int ix;
    t = byte_at(body, n, 1);
    v = {byte_at(body, n, 3), byte_at(body, n, 4)};
    if (t == 8'h02) begin
      ix = int'(byte_at(body, n, 2));
      cfg_m[ix*16 +: 16] = {byte_at(body, n, 3), byte_at(body, n, 4)};
    end
    if (t == 8'h04) begin
      v = {byte_at(body, n, 2), byte_at(body, n, 3)};
      base_m = v[11:0];
    end
  endtask

  task automatic run_frame(input vec_t v);
    logic [7:0] len;
    int u0, s0;
    len = byte_at(v.body, v.n, 0);
    if (v.n >= 2 && byte_at(v.body, v.n, 1) == 8'h05 && len > 8'd1 && ((len - 8'd1) % 8'd2) == 8'd0)
      for (int k = 0; k < int'(len - 8'd1) / 2; k++)
        exp_wr.push_back({base_m + 12'(k), byte_at(v.body, v.n, 2 + 2 * k),
                          byte_at(v.body, v.n, 3 + 2 * k)});
    exp_tx.push_back(v.resp);
    u0 = upd_cnt;
    s0 = srst_cnt;
    send_body(v.body, v.n, v.corrupt);
    wait_resp(v.name);
    tick();
    if (v.resp == 8'h06) model_commit(v.body, v.n);
    check({v.name, "_cfg"}, cfg, cfg_m);
    check({v.name, "_cfg_update"}, 64'(upd_cnt - u0), 64'(v.upd));
    check({v.name, "_sys_reset"}, 64'(srst_cnt - s0), 64'(v.srst));
    check({v.name, "_writes_left"}, 64'(exp_wr.size()), 64'd0);
    exp_wr.delete();
  endtask

  task automatic add(input string name, input logic [63:0] body, input int n,
                     input logic [7:0] corrupt, input logic [7:0] resp, input bit upd,
                     input bit srst);
    vec_t v;
    v.name = name; v.body = body; v.n = n; v.corrupt = corrupt;
    v.resp = resp; v.upd = upd; v.srst = srst;
    vecs.push_back(v);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_outs"}, 64'({tx_valid, tx_data, wr_enable, wr_addr, wr_data, cfg_update,
                                 sys_reset}), 64'd0);
    check({name, "_cfg"}, cfg, INIT);
  endtask

  task automatic wait_tx_valid(input string name);
    for (int c = 0; c < 40 && !tx_valid; c++) tick();
    check({name, "_pending"}, 64'(tx_valid), 64'd1);
  endtask

  initial begin
    vec_t v;
    logic [7:0] held;
    bit stable;

    add("cfg1_zero",     64'h04_02_01_00_00,    5, 8'h00, 8'h06, 1, 0);
    add("cfg3_beef",     64'h04_02_03_BE_EF,    5, 8'h00, 8'h06, 1, 0);
    add("cfg0_badchk",   64'h04_02_00_12_34,    5, 8'h01, 8'h15, 0, 0);
    add("cfg7_arg",      64'h04_02_07_12_34,    5, 8'h00, 8'h18, 0, 0);
    add("cfg_badlen",    64'h03_02_01_00,       4, 8'h00, 8'h16, 0, 0);
    add("type3_len1",    64'h01_03,             2, 8'h00, 8'h17, 0, 0);
    add("type0",         64'h02_00_55,          3, 8'h00, 8'h17, 0, 0);
    add("badtype_chk",   64'h02_09_00,          3, 8'h20, 8'h15, 0, 0);
    add("ram_len1",      64'h01_05,             2, 8'h00, 8'h16, 0, 0);
    add("sysrst",        64'h02_01_01,          3, 8'h00, 8'h06, 0, 1);
    add("sysrst_bit0",   64'h02_01_00,          3, 8'h00, 8'h06, 0, 0);
    add("sysrst_badchk", 64'h02_01_01,          3, 8'h01, 8'h15, 0, 0);
    add("base_100",      64'h03_04_01_00,       4, 8'h00, 8'h06, 0, 0);
    add("ram_two",       64'h05_05_12_34_AB_CD, 6, 8'h00, 8'h06, 0, 0);
    add("ram_odd",       64'h04_05_11_22_33,    5, 8'h00, 8'h16, 0, 0);
    add("base_fff",      64'h03_04_0F_FF,       4, 8'h00, 8'h06, 0, 0);
    add("ram_wrap",      64'h05_05_AA_BB_CC_DD, 6, 8'h00, 8'h06, 0, 0);
    add("base_trunc",    64'h03_04_FF_80,       4, 8'h00, 8'h06, 0, 0);
    add("ram_badchk",    64'h03_05_55_66,       4, 8'h01, 8'h15, 0, 0);
    add("base_badchk",   64'h03_04_02_00,       4, 8'h01, 8'h15, 0, 0);
    add("ram_after",     64'h03_05_77_88,       4, 8'h00, 8'h06, 0, 0);
    add("cfg0_cafe",     64'h04_02_00_CA_FE,    5, 8'h00, 8'h06, 1, 0);

    repeat (3) tick();
    reset = 1'b0;
    check_reset_outputs("reset");

    foreach (vecs[i]) run_frame(vecs[i]);

    // LEN=0 must be dropped while staying in idle
    send_byte(8'h00);
    add("after_len0", 64'h04_02_02_01_23, 5, 8'h00, 8'h06, 1, 0);
    run_frame(vecs[vecs.size() - 1]);

    // Stall inside a RAM frame past the timeout: silent return to idle
    send_byte(8'h03);
    send_byte(8'h05);
    repeat (TO + 1) tick();
    check("timeout_no_tx", 64'(tx_valid), 64'd0);
    add("after_timeout", 64'h04_02_01_0B_0C, 5, 8'h00, 8'h06, 1, 0);
    run_frame(vecs[vecs.size() - 1]);

    // Gap of one clock less than the timeout must not abort the frame
    exp_tx.push_back(8'h06);
    send_byte(8'h04);
    send_byte(8'h02);
    send_byte(8'h03);
    repeat (TO - 1) tick();
    send_byte(8'h44);
    send_byte(8'h55);
    send_byte(8'h00 - 8'h04 - 8'h02 - 8'h03 - 8'h44 - 8'h55);
    wait_resp("gap_below_timeout");
    cfg_m[3*16 +: 16] = 16'h4455;
    tick();
    check("gap_below_timeout_cfg", cfg, cfg_m);

    // Back-pressure during RESP; bytes arriving meanwhile are ignored
    tx_ready = 1'b0;
    exp_tx.push_back(8'h06);
    send_body(64'h04_02_02_5A_5A, 5, 8'h00);
    wait_tx_valid("hold");
    held = tx_data;
    stable = 1'b1;
    for (int i = 0; i < 50; i++) begin
      rx_valid = (i >= 10 && i <= 12);
      rx_data  = (i == 10) ? 8'h02 : 8'h01;
      tick();
      if (!tx_valid || tx_data !== held) stable = 1'b0;
    end
    rx_valid = 1'b0;
    check("hold_stable", 64'(stable), 64'd1);
    check("hold_data", 64'(held), 64'h06);
    tx_ready = 1'b1;
    wait_resp("hold");
    cfg_m[2*16 +: 16] = 16'h5A5A;
    v.name = "after_hold"; v.body = 64'h03_04_00_10; v.n = 4; v.corrupt = 8'h00;
    v.resp = 8'h06; v.upd = 1'b0; v.srst = 1'b0;
    run_frame(v);

    // Reset while a response is pending drops it
    tx_ready = 1'b0;
    exp_tx.push_back(8'h06);
    send_body(64'h04_02_00_99_99, 5, 8'h00);
    wait_tx_valid("resp_reset");
    exp_tx.delete();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tx_ready = 1'b1;
    check_reset_outputs("resp_reset");
    repeat (5) tick();
    cfg_m = INIT;
    base_m = 12'h000;

    // Reset in the middle of a payload
    send_byte(8'h04);
    send_byte(8'h02);
    send_byte(8'h01);
    send_byte(8'hAB);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_reset_outputs("payload_reset");
    v.name = "ram_after_reset"; v.body = 64'h03_05_01_02; v.n = 4; v.corrupt = 8'h00;
    v.resp = 8'h06; v.upd = 1'b0; v.srst = 1'b0;
    run_frame(v);

    repeat (5) tick();
    check("final_tx_queue", 64'(exp_tx.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
